// File: rtl/common_enums.sv
// Shared type and constant definitions for the chess clock.
//   clk_state_e  : controller state encoding (IDLE/RUNNING/PAUSED/FLAGGED)
//   CS_W         : width of a remaining-time value in centiseconds
//   TC_BASE_CS   : base time per time-control mode
//   TC_INC_CS    : per-move increment per time-control mode
//   sat_add      : 19-bit add of two time values, clamped to a ceiling
package common_enums;

    localparam int CS_W = 18;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        FLAGGED = 2'd3
    } clk_state_e;

    localparam logic [CS_W-1:0] TC_BASE_CS [4] = '{18'd6000, 18'd18000, 18'd60000, 18'd180000};
    localparam logic [CS_W-1:0] TC_INC_CS  [4] = '{18'd0,    18'd200,   18'd500,   18'd0};

    // One extra bit of headroom so the carry out is seen before clamping.
    function automatic logic [CS_W-1:0] sat_add(input logic [CS_W-1:0] a,
                                                 input logic [CS_W-1:0] b,
                                                 input logic [CS_W-1:0] max_v);
        logic [CS_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_v}) ? max_v : sum[CS_W-1:0];
    endfunction

endpackage

// File: rtl/clock_tick_gen.sv
// Prescaler producing a one-cycle tick every DIV enabled cycles.
//   clk, reset_n : clock, asynchronous active-low reset
//   en           : count enable; the count holds while low
//   clr          : synchronous clear to 0, wins over en
//   tick         : high during the enabled cycle in which the count wraps
module clock_tick_gen #(
    parameter int DIV = 500_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int               CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] TC    = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick = en && !clr && (cnt_q == TC);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= (cnt_q == TC) ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/chess_clock_ctrl.sv
// Two-player chess clock controller.
//   clk, reset_n             : clock, asynchronous active-low reset
//   start                    : pulse, load preset and begin a new game
//   move_done                : pulse, side to move finished its move
//   pause_toggle             : pulse, toggle RUNNING/PAUSED
//   mode_sel[1:0]            : time-control preset, sampled in IDLE and on start
//   state[1:0]               : clk_state_e
//   turn                     : side to move (0 white, 1 black)
//   white_cs/black_cs[17:0]  : remaining time in centiseconds
//   disp_cs[17:0]            : remaining time of the side to move
//   flag_white/flag_black    : time expired, held until start or reset
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no game; both clocks track the selected base time
// RUNNING | side to move counts down, moves add increment and hand off
// PAUSED  | prescaler and clocks frozen, moves ignored
// FLAGGED | a side reached zero; frozen until start or reset
module chess_clock_ctrl
    import common_enums::*;
#(
    parameter int              CLK_FREQ_HZ = 50_000_000,
    parameter logic [CS_W-1:0] MAX_CS      = 18'd262143
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            move_done,
    input  logic            pause_toggle,
    input  logic [1:0]      mode_sel,
    output logic [1:0]      state,
    output logic            turn,
    output logic [CS_W-1:0] white_cs,
    output logic [CS_W-1:0] black_cs,
    output logic [CS_W-1:0] disp_cs,
    output logic            flag_white,
    output logic            flag_black
);

    clk_state_e      state_q;
    logic            turn_q;
    logic [CS_W-1:0] white_q;
    logic [CS_W-1:0] black_q;
    logic            flag_w_q;
    logic            flag_b_q;
    // Mode is captured at start so later mode_sel changes cannot alter
    // the increment of a game in progress.
    logic [1:0]      mode_q;

    logic            tick;
    logic            tick_en;
    logic            tick_clr;
    logic            move_ok;
    logic [CS_W-1:0] active_cs;
    logic [CS_W-1:0] inc_sum_d;

    assign active_cs = turn_q ? black_q : white_q;
    assign inc_sum_d = sat_add(active_cs, TC_INC_CS[mode_q], MAX_CS);

    // A pause in the same cycle freezes the prescaler, and a move restarts
    // the next player's period from zero, so a coinciding tick is dropped.
    assign move_ok  = (state_q == RUNNING) && move_done && !pause_toggle && !start;
    assign tick_en  = (state_q == RUNNING) && !pause_toggle && !start;
    assign tick_clr = start || move_ok;

    clock_tick_gen #(
        .DIV (CLK_FREQ_HZ / 100)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (tick_en),
        .clr     (tick_clr),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            turn_q   <= 1'b0;
            white_q  <= '0;
            black_q  <= '0;
            flag_w_q <= 1'b0;
            flag_b_q <= 1'b0;
            mode_q   <= 2'd0;
        end else if (start) begin
            state_q  <= RUNNING;
            turn_q   <= 1'b0;
            white_q  <= TC_BASE_CS[mode_sel];
            black_q  <= TC_BASE_CS[mode_sel];
            flag_w_q <= 1'b0;
            flag_b_q <= 1'b0;
            mode_q   <= mode_sel;
        end else begin
            case (state_q)
                IDLE: begin
                    white_q <= TC_BASE_CS[mode_sel];
                    black_q <= TC_BASE_CS[mode_sel];
                    turn_q  <= 1'b0;
                end
                RUNNING: begin
                    if (pause_toggle) begin
                        state_q <= PAUSED;
                    end else if (move_done) begin
                        if (turn_q) black_q <= inc_sum_d;
                        else        white_q <= inc_sum_d;
                        turn_q <= ~turn_q;
                    end else if (tick && (active_cs != '0)) begin
                        if (turn_q) black_q <= active_cs - CS_W'(1);
                        else        white_q <= active_cs - CS_W'(1);
                        if (active_cs == CS_W'(1)) begin
                            state_q <= FLAGGED;
                            if (turn_q) flag_b_q <= 1'b1;
                            else        flag_w_q <= 1'b1;
                        end
                    end
                end
                PAUSED: begin
                    if (pause_toggle) state_q <= RUNNING;
                end
                default: begin
                end
            endcase
        end
    end

    assign state      = state_q;
    assign turn       = turn_q;
    assign white_cs   = white_q;
    assign black_cs   = black_q;
    assign disp_cs    = active_cs;
    assign flag_white = flag_w_q;
    assign flag_black = flag_b_q;

endmodule

// File: tb/tb_chess_clock_ctrl.sv
module tb_chess_clock_ctrl;

    localparam int DIV1 = 10;
    localparam int MAXV = 262143;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        start = 1'b0, move_done = 1'b0, pause_toggle = 1'b0;
    logic [1:0]  mode_sel = 2'd1;
    logic [1:0]  state;
    logic        turn;
    logic [17:0] white_cs, black_cs, disp_cs;
    logic        flag_white, flag_black;

    logic        start2 = 1'b0, move2 = 1'b0, pause2 = 1'b0;
    logic [1:0]  mode_sel2 = 2'd0;
    logic [1:0]  state2;
    logic        turn2;
    logic [17:0] white2, black2, disp2;
    logic        fw2, fb2;

    chess_clock_ctrl #(.CLK_FREQ_HZ(1000)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .move_done(move_done),
        .pause_toggle(pause_toggle), .mode_sel(mode_sel), .state(state), .turn(turn),
        .white_cs(white_cs), .black_cs(black_cs), .disp_cs(disp_cs),
        .flag_white(flag_white), .flag_black(flag_black)
    );

    chess_clock_ctrl #(.CLK_FREQ_HZ(200)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .move_done(move2),
        .pause_toggle(pause2), .mode_sel(mode_sel2), .state(state2), .turn(turn2),
        .white_cs(white2), .black_cs(black2), .disp_cs(disp2),
        .flag_white(fw2), .flag_black(fb2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model for dut: game rules expressed with plain integers.
    // m_elapsed counts running cycles since the period last restarted.
    int m_state, m_turn, m_elapsed, m_mode;
    int m_cs   [2];
    int m_flag [2];

    function automatic int base_of(input int m);
        case (m)
            0:       return 6000;
            1:       return 18000;
            2:       return 60000;
            default: return 180000;
        endcase
    endfunction

    function automatic int inc_of(input int m);
        case (m)
            1:       return 200;
            2:       return 500;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_state = 0; m_turn = 0; m_elapsed = 0; m_mode = 0;
        m_cs[0] = 0; m_cs[1] = 0; m_flag[0] = 0; m_flag[1] = 0;
    endtask

    task automatic model_step(input bit st, input bit mv, input bit pt, input int ms);
        int s;
        if (st) begin
            m_cs[0] = base_of(ms); m_cs[1] = base_of(ms);
            m_turn = 0; m_flag[0] = 0; m_flag[1] = 0;
            m_elapsed = 0; m_mode = ms; m_state = 1;
        end else if (m_state == 0) begin
            m_cs[0] = base_of(ms); m_cs[1] = base_of(ms); m_turn = 0;
        end else if (m_state == 1) begin
            if (pt) begin
                m_state = 2;
            end else if (mv) begin
                s = m_cs[m_turn] + inc_of(m_mode);
                m_cs[m_turn] = (s > MAXV) ? MAXV : s;
                m_turn = 1 - m_turn;
                m_elapsed = 0;
            end else begin
                m_elapsed++;
                if ((m_elapsed % DIV1) == 0 && m_cs[m_turn] > 0) begin
                    m_cs[m_turn]--;
                    if (m_cs[m_turn] == 0) begin
                        m_flag[m_turn] = 1;
                        m_state = 3;
                    end
                end
            end
        end else if (m_state == 2) begin
            if (pt) m_state = 1;
        end
    endtask

    // One clock: model follows dut, all dut outputs compared, pulses cleared.
    task automatic tick_clk();
        @(posedge clk);
        if (!reset_n) model_reset();
        else          model_step(start, move_done, pause_toggle, int'(mode_sel));
        #1;
        chk("m_state", int'(state), m_state);
        chk("m_turn",  int'(turn), m_turn);
        chk("m_white", int'(white_cs), m_cs[0]);
        chk("m_black", int'(black_cs), m_cs[1]);
        chk("m_disp",  int'(disp_cs), m_cs[m_turn]);
        chk("m_flag_w", int'(flag_white), m_flag[0]);
        chk("m_flag_b", int'(flag_black), m_flag[1]);
        start = 1'b0; move_done = 1'b0; pause_toggle = 1'b0;
        start2 = 1'b0; move2 = 1'b0; pause2 = 1'b0;
    endtask

    typedef struct {
        bit st, mv, pt;
        int ms;
        int e_state, e_turn, e_white, e_black;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(input bit st, input bit mv, input bit pt, input int ms,
                                input int es, input int et, input int ew, input int eb);
        vec_t v;
        v.st = st; v.mv = mv; v.pt = pt; v.ms = ms;
        v.e_state = es; v.e_turn = et; v.e_white = ew; v.e_black = eb;
        return v;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        //            st mv pt ms  state turn white  black
        vecs[0]  = mk(0, 0, 0, 1,  0,    0,   18000, 18000);
        vecs[1]  = mk(0, 0, 0, 2,  0,    0,   60000, 60000);
        vecs[2]  = mk(0, 0, 0, 1,  0,    0,   18000, 18000);
        vecs[3]  = mk(1, 0, 0, 1,  1,    0,   18000, 18000);
        vecs[4]  = mk(0, 1, 0, 1,  1,    1,   18200, 18000);
        vecs[5]  = mk(0, 1, 1, 1,  2,    1,   18200, 18000);
        vecs[6]  = mk(0, 1, 0, 1,  2,    1,   18200, 18000);
        vecs[7]  = mk(0, 0, 1, 1,  1,    1,   18200, 18000);
        vecs[8]  = mk(0, 1, 0, 3,  1,    0,   18200, 18200);
        vecs[9]  = mk(1, 0, 0, 0,  1,    0,   6000,  6000);
        vecs[10] = mk(0, 1, 0, 0,  1,    1,   6000,  6000);
        vecs[11] = mk(0, 0, 1, 0,  2,    1,   6000,  6000);
        vecs[12] = mk(1, 0, 0, 2,  1,    0,   60000, 60000);
        vecs[13] = mk(0, 0, 0, 1,  1,    0,   60000, 60000);

        model_reset();
        repeat (3) tick_clk();
        chk("rst_state", int'(state), 0);
        chk("rst_white", int'(white_cs), 0);
        chk("rst_flags", int'({flag_white, flag_black}), 0);
        reset_n = 1'b1;
        mode_sel = 2'd1;
        repeat (2) tick_clk();
        chk("rst_base_white", int'(white_cs), 18000);
        chk("rst_base_black", int'(black_cs), 18000);
        chk("rst_turn", int'(turn), 0);

        for (int i = 0; i < 14; i++) begin
            start = vecs[i].st; move_done = vecs[i].mv; pause_toggle = vecs[i].pt;
            mode_sel = 2'(vecs[i].ms);
            tick_clk();
            chk($sformatf("vec%0d_state", i), int'(state), vecs[i].e_state);
            chk($sformatf("vec%0d_turn", i),  int'(turn), vecs[i].e_turn);
            chk($sformatf("vec%0d_white", i), int'(white_cs), vecs[i].e_white);
            chk($sformatf("vec%0d_black", i), int'(black_cs), vecs[i].e_black);
            chk($sformatf("vec%0d_disp", i),  int'(disp_cs),
                vecs[i].e_turn ? vecs[i].e_black : vecs[i].e_white);
            chk($sformatf("vec%0d_flags", i), int'({flag_white, flag_black}), 0);
        end

        // Countdown and hand-off
        mode_sel = 2'd1; start = 1'b1; tick_clk();
        repeat (54) tick_clk();
        chk("cd_white_54", int'(white_cs), 17995);
        move_done = 1'b1; tick_clk();
        chk("cd_move_white", int'(white_cs), 18195);
        chk("cd_move_turn", int'(turn), 1);
        repeat (9) tick_clk();
        chk("cd_black_pre", int'(black_cs), 18000);
        tick_clk();
        chk("cd_black_tick", int'(black_cs), 17999);

        // Pause with a residual prescaler count of 3
        repeat (3) tick_clk();
        pause_toggle = 1'b1; tick_clk();
        chk("pz_state", int'(state), 2);
        repeat (100) tick_clk();
        chk("pz_hold_black", int'(black_cs), 17999);
        chk("pz_hold_white", int'(white_cs), 18195);
        pause_toggle = 1'b1; tick_clk();
        chk("pz_resume", int'(state), 1);
        repeat (6) tick_clk();
        chk("pz_black_pre", int'(black_cs), 17999);
        tick_clk();
        chk("pz_black_tick", int'(black_cs), 17998);

        // Saturation through quick moves in mode 2
        mode_sel = 2'd2; start = 1'b1; tick_clk();
        for (int k = 0; k < 808; k++) begin
            move_done = 1'b1; tick_clk();
        end
        chk("sat_white_404", int'(white_cs), 262000);
        chk("sat_black_404", int'(black_cs), 262000);
        move_done = 1'b1; tick_clk();
        chk("sat_white_clamp", int'(white_cs), MAXV);
        move_done = 1'b1; tick_clk();
        chk("sat_black_clamp", int'(black_cs), MAXV);
        move_done = 1'b1; tick_clk();
        chk("sat_white_stay", int'(white_cs), MAXV);

        // Asynchronous reset mid-game
        reset_n = 1'b0;
        #1;
        chk("arst_state", int'(state), 0);
        chk("arst_white", int'(white_cs), 0);
        chk("arst_black", int'(black_cs), 0);
        chk("arst_turn", int'(turn), 0);
        repeat (2) tick_clk();
        reset_n = 1'b1;
        mode_sel = 2'd1;
        repeat (2) tick_clk();
        chk("arst_reload", int'(white_cs), 18000);

        // dut2: one tick every 2 cycles, mode 0
        mode_sel2 = 2'd0; start2 = 1'b1; tick_clk();
        chk("d2_start_state", int'(state2), 1);
        chk("d2_start_white", int'(white2), 6000);
        repeat (11998) tick_clk();
        chk("d2_white_one", int'(white2), 1);
        tick_clk();
        move2 = 1'b1; tick_clk();
        chk("col_white", int'(white2), 1);
        chk("col_turn", int'(turn2), 1);
        chk("col_flag", int'(fw2), 0);
        chk("col_state", int'(state2), 1);
        pause2 = 1'b1; move2 = 1'b1; tick_clk();
        chk("colpm_state", int'(state2), 2);
        chk("colpm_turn", int'(turn2), 1);
        pause2 = 1'b1; tick_clk();
        chk("colpm_resume", int'(state2), 1);
        move2 = 1'b1; tick_clk();
        chk("hand_turn", int'(turn2), 0);
        chk("hand_black", int'(black2), 6000);
        tick_clk();
        chk("fl_pre_white", int'(white2), 1);
        chk("fl_pre_state", int'(state2), 1);
        tick_clk();
        chk("fl_white", int'(white2), 0);
        chk("fl_flag_w", int'(fw2), 1);
        chk("fl_flag_b", int'(fb2), 0);
        chk("fl_state", int'(state2), 3);
        chk("fl_disp", int'(disp2), 0);
        move2 = 1'b1; tick_clk();
        pause2 = 1'b1; tick_clk();
        repeat (5) tick_clk();
        chk("fl_hold_state", int'(state2), 3);
        chk("fl_hold_turn", int'(turn2), 0);
        chk("fl_hold_black", int'(black2), 6000);
        chk("fl_hold_flag", int'(fw2), 1);
        start2 = 1'b1; tick_clk();
        chk("fl_restart_state", int'(state2), 1);
        chk("fl_restart_white", int'(white2), 6000);
        chk("fl_restart_black", int'(black2), 6000);
        chk("fl_restart_flags", int'({fw2, fb2}), 0);

        got = -1;
        for (int k = 1; k <= 12010; k++) begin
            tick_clk();
            if (fw2) begin
                got = k;
                break;
            end
        end
        chk("flag_cycles", got, 12000);
        chk("flag_full_white", int'(white2), 0);
        chk("flag_full_black", int'(black2), 6000);
        chk("flag_full_state", int'(state2), 3);

        // Randomized traffic on dut against the model
        for (int i = 0; i < 3000; i++) begin
            start        = ($urandom_range(0, 99) == 0);
            move_done    = ($urandom_range(0, 5) == 0);
            pause_toggle = ($urandom_range(0, 15) == 0);
            mode_sel     = 2'($urandom_range(0, 3));
            tick_clk();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
